// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - ID-stage hazard, redirect and interrupt sequencing control
module hazard_control_unit #(
    parameter logic [31:0] ISR_VECTOR = 32'h0000_0200,
    parameter logic [5:0]  ERET_OP    = 6'h10,
    parameter logic [5:0]  ERET_FUNCT = 6'h18,
    parameter logic [5:0]  J_OP       = 6'h02,
    parameter logic [5:0]  JAL_OP     = 6'h03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IFID_IR,
    input  logic [31:0] IFID_PC,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_rt,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        intr,
    output logic        Stall,
    output logic        Flush,
    output logic        pc_ld,
    output logic        pc_inc,
    output logic [31:0] PC_in,
    output logic        ISR,
    output logic [2:0]  LISR,
    output logic        int_ack,
    output logic        in_service,
    output logic [31:0] EPC
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ENTER  = 3'd1,
        VECTOR = 3'd2,
        INSVC  = 3'd3,
        EXIT1  = 3'd4,
        EXIT2  = 3'd5,
        EXIT3  = 3'd6
    } state_t;

    state_t state, state_nxt;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       uses_rt;
    logic       load_use;
    logic       is_jump;
    logic       is_eret;
    logic       take_intr;

    assign opcode = IFID_IR[31:26];
    assign rs     = IFID_IR[25:21];
    assign rt     = IFID_IR[20:16];
    assign funct  = IFID_IR[5:0];

    // rt is a source only for R-type, stores (sb/sh/sw) and branches (beq/bne/blez/bgtz)
    always_comb begin
        uses_rt = 1'b0;
        case (opcode)
            6'h00, 6'h28, 6'h29, 6'h2b,
            6'h04, 6'h05, 6'h06, 6'h07: uses_rt = 1'b1;
            default:                    uses_rt = 1'b0;
        endcase
    end

    assign load_use = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                      ((IDEX_rt == rs) || (uses_rt && (IDEX_rt == rt)));
    assign is_jump  = (opcode == J_OP) || (opcode == JAL_OP);
    assign is_eret  = (opcode == ERET_OP) && (funct == ERET_FUNCT);

    assign take_intr = rst && (state == IDLE) && intr && !branch_taken &&
                       !load_use && !is_jump;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            EPC   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (take_intr) begin
                EPC <= IFID_PC;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        Stall      = 1'b0;
        Flush      = 1'b0;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        PC_in      = 32'd0;
        ISR        = 1'b0;
        LISR       = 3'b000;
        int_ack    = 1'b0;
        in_service = 1'b0;
        if (rst) begin
            if ((state == IDLE) || (state == INSVC)) begin
                if (branch_taken) begin
                    pc_ld = 1'b1;
                    PC_in = branch_target;
                    Flush = 1'b1;
                end else if (load_use) begin
                    Stall = 1'b1;
                end else if (is_jump) begin
                    pc_ld = 1'b1;
                    PC_in = {IFID_PC[31:28], IFID_IR[25:0], 2'b00};
                    Flush = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (take_intr) begin
                        state_nxt = ENTER;
                    end
                end
                ENTER: begin
                    ISR       = 1'b1;
                    Stall     = 1'b1;
                    state_nxt = VECTOR;
                end
                VECTOR: begin
                    pc_ld     = 1'b1;
                    PC_in     = ISR_VECTOR;
                    Flush     = 1'b1;
                    int_ack   = 1'b1;
                    state_nxt = INSVC;
                end
                INSVC: begin
                    in_service = 1'b1;
                    if (is_eret && !branch_taken) begin
                        state_nxt = EXIT1;
                    end
                end
                EXIT1: begin
                    LISR      = 3'b001;
                    Stall     = 1'b1;
                    state_nxt = EXIT2;
                end
                EXIT2: begin
                    LISR      = 3'b010;
                    Stall     = 1'b1;
                    state_nxt = EXIT3;
                end
                EXIT3: begin
                    // Flushing here discards the ERET still sitting in IF/ID
                    LISR      = 3'b100;
                    pc_ld     = 1'b1;
                    PC_in     = EPC;
                    Flush     = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

    logic        clk;
    logic        rst;
    logic [31:0] IFID_IR;
    logic [31:0] IFID_PC;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_rt;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        intr;
    logic        Stall;
    logic        Flush;
    logic        pc_ld;
    logic        pc_inc;
    logic [31:0] PC_in;
    logic        ISR;
    logic [2:0]  LISR;
    logic        int_ack;
    logic        in_service;
    logic [31:0] EPC;

    hazard_control_unit dut (
        .clk(clk), .rst(rst), .IFID_IR(IFID_IR), .IFID_PC(IFID_PC),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rt(IDEX_rt),
        .branch_taken(branch_taken), .branch_target(branch_target), .intr(intr),
        .Stall(Stall), .Flush(Flush), .pc_ld(pc_ld), .pc_inc(pc_inc), .PC_in(PC_in),
        .ISR(ISR), .LISR(LISR), .int_ack(int_ack), .in_service(in_service), .EPC(EPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // control bits: Stall Flush pc_ld pc_inc ISR LISR[2:0] int_ack in_service
    localparam logic [9:0] C_ZERO  = 10'h000;
    localparam logic [9:0] C_INC   = 10'h040;
    localparam logic [9:0] C_STALL = 10'h200;
    localparam logic [9:0] C_REDIR = 10'h180;
    localparam logic [9:0] C_ENTER = 10'h220;
    localparam logic [9:0] C_VEC   = 10'h182;
    localparam logic [9:0] C_SVC   = 10'h001;
    localparam logic [9:0] C_EXIT1 = 10'h204;
    localparam logic [9:0] C_EXIT2 = 10'h208;
    localparam logic [9:0] C_EXIT3 = 10'h190;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] ADD_RS8  = 32'h010A_4820;
    localparam logic [31:0] ADD_RT8  = 32'h0148_4820;
    localparam logic [31:0] ADDI_RT8 = 32'h2008_0005;
    localparam logic [31:0] SW_RT8   = 32'hAC08_0000;
    localparam logic [31:0] J_100    = 32'h0800_0100;
    localparam logic [31:0] J_RS16   = 32'h0A00_0100;
    localparam logic [31:0] ERET     = 32'h4200_0018;

    typedef struct {
        string       tag;
        logic [9:0]  ctl;
        logic [31:0] pcin;
        logic [31:0] epc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic r, input logic [31:0] ir,
                         input logic [31:0] pc, input logic mr, input logic [4:0] rtv,
                         input logic bt, input logic [31:0] bta, input logic it,
                         input logic [9:0] ectl, input logic [31:0] epcin,
                         input logic [31:0] eepc);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        IFID_IR       = ir;
        IFID_PC       = pc;
        IDEX_MemRead  = mr;
        IDEX_rt       = rtv;
        branch_taken  = bt;
        branch_target = bta;
        intr          = it;
        e.tag  = tag;
        e.ctl  = ectl;
        e.pcin = epcin;
        e.epc  = eepc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [9:0] obs;
            e   = q.pop_front();
            obs = {Stall, Flush, pc_ld, pc_inc, ISR, LISR, int_ack, in_service};
            check({e.tag, ".ctl"}, {22'd0, obs}, {22'd0, e.ctl});
            check({e.tag, ".pc_in"}, PC_in, e.pcin);
            check({e.tag, ".epc"}, EPC, e.epc);
            if (Stall && Flush) check({e.tag, ".stall_flush"}, 32'd1, 32'd0);
        end
    end

    initial begin
        rst = 1'b0; IFID_IR = NOP; IFID_PC = 32'h0; IDEX_MemRead = 1'b0; IDEX_rt = 5'd0;
        branch_taken = 1'b0; branch_target = 32'h0; intr = 1'b0;
        //     tag            rst ir        pc            mr  rt   bt  bta           int ctl              pc_in         epc
        drive("reset",        0, NOP,      32'h10,       0, 0,  0, 32'h0,        0, C_ZERO,          32'h0,        32'h0);
        drive("seq",          1, NOP,      32'h10,       0, 0,  0, 32'h0,        0, C_INC,           32'h0,        32'h0);
        drive("lu_rs",        1, ADD_RS8,  32'h14,       1, 8,  0, 32'h0,        0, C_STALL,         32'h0,        32'h0);
        drive("lu_rt0",       1, ADD_RS8,  32'h14,       1, 0,  0, 32'h0,        0, C_INC,           32'h0,        32'h0);
        drive("lu_rt_rtype",  1, ADD_RT8,  32'h18,       1, 8,  0, 32'h0,        0, C_STALL,         32'h0,        32'h0);
        drive("lu_addi_dst",  1, ADDI_RT8, 32'h18,       1, 8,  0, 32'h0,        0, C_INC,           32'h0,        32'h0);
        drive("lu_store",     1, SW_RT8,   32'h1c,       1, 8,  0, 32'h0,        0, C_STALL,         32'h0,        32'h0);
        drive("br_over_lu",   1, ADD_RS8,  32'h20,       1, 8,  1, 32'h40,       0, C_REDIR,         32'h40,       32'h0);
        drive("jump",         1, J_100,    32'h1000_0010,0, 0,  0, 32'h0,        0, C_REDIR,         32'h1000_0400,32'h0);
        drive("lu_over_jump", 1, J_RS16,   32'h1000_0010,1, 16, 0, 32'h0,        0, C_STALL,         32'h0,        32'h0);
        drive("intr_defer",   1, NOP,      32'h20,       0, 0,  1, 32'h80,       1, C_REDIR,         32'h80,       32'h0);
        drive("intr_accept",  1, NOP,      32'h24,       0, 0,  0, 32'h0,        1, C_INC,           32'h0,        32'h0);
        drive("enter",        1, NOP,      32'h24,       0, 0,  0, 32'h0,        1, C_ENTER,         32'h0,        32'h24);
        drive("vector",       1, NOP,      32'h24,       0, 0,  0, 32'h0,        1, C_VEC,           32'h200,      32'h24);
        drive("insvc",        1, NOP,      32'h200,      0, 0,  0, 32'h0,        1, C_INC | C_SVC,   32'h0,        32'h24);
        drive("eret_br",      1, ERET,     32'h204,      0, 0,  1, 32'h300,      1, C_REDIR | C_SVC, 32'h300,      32'h24);
        drive("insvc_lu",     1, ADD_RS8,  32'h300,      1, 8,  0, 32'h0,        1, C_STALL | C_SVC, 32'h0,        32'h24);
        drive("eret",         1, ERET,     32'h304,      0, 0,  0, 32'h0,        1, C_INC | C_SVC,   32'h0,        32'h24);
        drive("exit1",        1, ERET,     32'h304,      0, 0,  0, 32'h0,        1, C_EXIT1,         32'h0,        32'h24);
        drive("exit2",        1, ERET,     32'h304,      0, 0,  0, 32'h0,        1, C_EXIT2,         32'h0,        32'h24);
        drive("exit3",        1, ERET,     32'h304,      0, 0,  0, 32'h0,        1, C_EXIT3,         32'h24,       32'h24);
        drive("reenter",      1, NOP,      32'h50,       0, 0,  0, 32'h0,        1, C_INC,           32'h0,        32'h24);
        drive("enter2",       1, NOP,      32'h50,       0, 0,  0, 32'h0,        0, C_ENTER,         32'h0,        32'h50);
        drive("vector2",      1, NOP,      32'h50,       0, 0,  0, 32'h0,        0, C_VEC,           32'h200,      32'h50);
        drive("insvc2",       1, ERET,     32'h200,      0, 0,  0, 32'h0,        0, C_INC | C_SVC,   32'h0,        32'h50);
        drive("exit1_2",      1, ERET,     32'h200,      0, 0,  0, 32'h0,        0, C_EXIT1,         32'h0,        32'h50);
        drive("reset_exit2",  0, ERET,     32'h200,      0, 0,  0, 32'h0,        0, C_ZERO,          32'h0,        32'h0);
        drive("post_reset",   1, NOP,      32'h60,       0, 0,  0, 32'h0,        0, C_INC,           32'h0,        32'h0);
        drive("eret_idle",    1, ERET,     32'h64,       0, 0,  0, 32'h0,        0, C_INC,           32'h0,        32'h0);
        drive("after_eret",   1, NOP,      32'h68,       0, 0,  0, 32'h0,        0, C_INC,           32'h0,        32'h0);
        repeat (2) @(posedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
